// File: rtl/bsg_1_to_n_tagged_fifo_buffered_pkg.sv
// Shared widths and helpers for the tagged 1-to-n buffered demux.
// Widths are derived from the channel count and per-channel depth.
package bsg_tagged_pkg;

  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int count_width(input int els);
    return $clog2(els + 1);
  endfunction

  function automatic int ptr_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

  function automatic logic tag_in_range(
    input int unsigned tag,
    input int unsigned n
  );
    return tag < n;
  endfunction

endpackage

// File: rtl/bsg_1_to_n_tagged_fifo_buffered_if.sv
// Tagged input stream plus per-channel valid/yumi output bundle.
// The slave side is the demux, the master side drives and consumes.
interface bsg_1_to_n_tagged_fifo_buffered_if
  import bsg_tagged_pkg::*;
#(
  parameter int num_out_p = 32,
  parameter int width_p   = 32,
  parameter int els_p     = 4
) ();

  localparam int tag_width_lp = tag_width(num_out_p);
  localparam int cnt_w_lp     = count_width(els_p);

  logic                          v_i;
  logic [width_p-1:0]            data_i;
  logic [tag_width_lp-1:0]       tag_i;
  logic                          yumi_o;
  logic                          drop_o;
  logic [num_out_p-1:0]          v_o;
  logic [num_out_p*width_p-1:0]  data_o;
  logic [num_out_p-1:0]          yumi_i;
  logic [num_out_p*cnt_w_lp-1:0] count_o;

  modport slave (
    input  v_i, data_i, tag_i, yumi_i,
    output yumi_o, drop_o, v_o, data_o, count_o
  );

  modport master (
    output v_i, data_i, tag_i, yumi_i,
    input  yumi_o, drop_o, v_o, data_o, count_o
  );

endinterface

// File: rtl/bsg_1_to_n_tagged_fifo_buffered_channel.sv
// One per-channel FIFO: registered head, no fall-through.
// Push is refused when full, even if a pop happens that cycle.
module bsg_tagged_fifo_channel
  import bsg_tagged_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p   = 4,
  localparam int cnt_w_lp = count_width(els_p),
  localparam int ptr_w_lp = ptr_width(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                v_i,
  input  logic [width_p-1:0]  data_i,
  output logic                full_o,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  input  logic                yumi_i,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [ptr_w_lp-1:0] rd_q, rd_d;
  logic [ptr_w_lp-1:0] wr_q, wr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic [width_p-1:0]  mem_q [els_p];
  logic                push;
  logic                pop;

  // Wrap explicitly so non-power-of-2 depths work.
  function automatic logic [ptr_w_lp-1:0] bump(
    input logic [ptr_w_lp-1:0] p
  );
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == cnt_w_lp'(els_p));
  assign v_o     = (cnt_q != '0);
  assign push    = v_i & ~full_o;
  assign pop     = yumi_i & v_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (push) wr_d = bump(wr_q);
    if (pop)  rd_d = bump(rd_q);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= data_i;
  end

  a_pop_needs_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    !(yumi_i && !v_o)
  );

endmodule

// File: rtl/bsg_1_to_n_tagged_fifo_buffered.sv
// Tag decode, input accept/drop and output concatenation over
// num_out_p independent channel FIFOs.
module bsg_1_to_n_tagged_fifo_buffered
  import bsg_tagged_pkg::*;
#(
  parameter int num_out_p = 32,
  parameter int width_p   = 32,
  parameter int els_p     = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_1_to_n_tagged_fifo_buffered_if.slave io
);

  localparam int cnt_w_lp = count_width(els_p);

  logic                          in_range;
  logic                          full_sel;
  logic [num_out_p-1:0]          hit;
  logic [num_out_p-1:0]          full;
  logic [num_out_p-1:0]          v_w;
  logic [num_out_p*width_p-1:0]  data_w;
  logic [num_out_p*cnt_w_lp-1:0] cnt_w;

  // Out-of-range tags select no channel, so full_sel stays 0.
  always_comb begin
    hit      = '0;
    full_sel = 1'b0;
    for (int k = 0; k < num_out_p; k++) begin
      if (int'(io.tag_i) == k) begin
        hit[k]   = 1'b1;
        full_sel = full[k];
      end
    end
  end

  assign in_range  = tag_in_range(32'(io.tag_i), num_out_p);
  assign io.yumi_o = reset_n_i & io.v_i & (~in_range | ~full_sel);
  assign io.drop_o = reset_n_i & io.v_i & ~in_range;

  for (genvar k = 0; k < num_out_p; k++) begin : g_ch
    bsg_tagged_fifo_channel #(
      .width_p (width_p),
      .els_p   (els_p)
    ) u_ch (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (reset_n_i & io.v_i & hit[k]),
      .data_i    (io.data_i),
      .full_o    (full[k]),
      .v_o       (v_w[k]),
      .data_o    (data_w[k*width_p +: width_p]),
      .yumi_i    (io.yumi_i[k]),
      .count_o   (cnt_w[k*cnt_w_lp +: cnt_w_lp])
    );
  end

  assign io.v_o     = v_w;
  assign io.data_o  = data_w;
  assign io.count_o = cnt_w;

endmodule
